// File: rtl/cnn1d_pkg.sv
// rtl/cnn1d_pkg.sv - shared types and helpers for the cnn1d front-end blocks
package cnn1d_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/subsample_scheduler_if.sv
// rtl/subsample_scheduler_if.sv - per-channel sample inputs and tagged shared output stream
interface subsample_scheduler_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 12,
  parameter int CHAN_WIDTH   = 2
);
  logic [NUM_CHANNELS-1:0]            sched_valid_in;
  logic [NUM_CHANNELS-1:0]            sched_ready_in;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] sched_data_in;
  logic                               sched_ready_out;
  logic                               sched_valid_out;
  logic [DATA_WIDTH-1:0]              sched_data_out;
  logic [CHAN_WIDTH-1:0]              sched_chan_out;
  logic                               sched_last_out;

  // master: the scheduler itself; slave: front ends plus downstream stage
  modport master (
    input  sched_valid_in, sched_data_in, sched_ready_out,
    output sched_ready_in, sched_valid_out, sched_data_out, sched_chan_out, sched_last_out
  );

  modport slave (
    output sched_valid_in, sched_data_in, sched_ready_out,
    input  sched_ready_in, sched_valid_out, sched_data_out, sched_chan_out, sched_last_out
  );
endinterface

// File: rtl/subsample_scheduler_rr_pick.sv
// rtl/subsample_scheduler_rr_pick.sv - combinational round-robin search from a start pointer
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  // Walk offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    int j;
    j       = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(i_start) + i;
      if (j >= N) j = j - N;
      if (i_req[j]) begin
        o_found = 1'b1;
        o_idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/subsample_scheduler.sv
// rtl/subsample_scheduler.sv - grants one channel per BURST_LEN-sample window onto the shared subsample stage
module subsample_scheduler
  import cnn1d_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 12,
  parameter int BURST_LEN    = 400
) (
  input logic                    clk,
  input logic                    rst,
  subsample_scheduler_if.master  bus
);

  localparam int CHAN_WIDTH    = (clog2(NUM_CHANNELS) > 1) ? clog2(NUM_CHANNELS) : 1;
  localparam int COUNTER_WIDTH = (clog2(BURST_LEN) > 1) ? clog2(BURST_LEN) : 1;
  localparam logic [CHAN_WIDTH-1:0]    LAST_CHAN  = CHAN_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(BURST_LEN - 1);

  sched_state_t              r_state, w_next_state;
  logic [CHAN_WIDTH-1:0]     r_grant, r_rr_ptr, r_chan_out, w_pick_idx;
  logic [COUNTER_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0]     r_data_out, w_sel_data;
  logic                      r_valid_out, r_last_out;
  logic                      w_pick_found, w_sel_valid, w_out_ready, w_in_hs, w_last_beat;
  logic [NUM_CHANNELS-1:0]   w_ready_in;

  rr_pick #(.N(NUM_CHANNELS), .W(CHAN_WIDTH)) u_rr_pick (
    .i_req   (bus.sched_valid_in),
    .i_start (r_rr_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (r_grant == CHAN_WIDTH'(c)) begin
        w_sel_valid = bus.sched_valid_in[c];
        w_sel_data  = bus.sched_data_in[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output register can take a new sample when empty or draining this cycle.
  assign w_out_ready = !r_valid_out || bus.sched_ready_out;
  assign w_last_beat = (r_count == LAST_COUNT);

  always_comb begin
    w_next_state = r_state;
    w_ready_in   = '0;
    w_in_hs      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_found) w_next_state = BURST;
      end
      BURST: begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          w_ready_in[c] = (r_grant == CHAN_WIDTH'(c)) && w_out_ready;
        end
        w_in_hs = w_sel_valid && w_out_ready;
        if (w_in_hs && w_last_beat) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_grant  <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
    end else if (r_state == IDLE) begin
      if (w_pick_found) begin
        r_grant <= w_pick_idx;
        r_count <= '0;
      end
    end else if (w_in_hs) begin
      if (w_last_beat) begin
        r_count  <= '0;
        r_rr_ptr <= (r_grant == LAST_CHAN) ? '0 : r_grant + 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_chan_out  <= '0;
      r_last_out  <= 1'b0;
    end else if (w_in_hs) begin
      r_valid_out <= 1'b1;
      r_data_out  <= w_sel_data;
      r_chan_out  <= r_grant;
      r_last_out  <= w_last_beat;
    end else if (r_valid_out && bus.sched_ready_out) begin
      r_valid_out <= 1'b0;
    end
  end

  assign bus.sched_ready_in  = w_ready_in;
  assign bus.sched_valid_out = r_valid_out;
  assign bus.sched_data_out  = r_data_out;
  assign bus.sched_chan_out  = r_chan_out;
  assign bus.sched_last_out  = r_last_out;

endmodule

// File: tb/tb_subsample_scheduler.sv
// tb/tb_subsample_scheduler.sv - scoreboard bench for subsample_scheduler (BURST_LEN 4 and 1 instances)
module tb_subsample_scheduler;
  localparam int NC = 4;
  localparam int DW = 12;
  localparam int CW = 2;
  localparam int SW = DW + CW + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  subsample_scheduler_if #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .CHAN_WIDTH(CW)) bus0 ();
  subsample_scheduler_if #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .CHAN_WIDTH(CW)) bus1 ();

  subsample_scheduler #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .BURST_LEN(4)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  subsample_scheduler #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .BURST_LEN(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int seq0 [NC];
  int seq1 [NC];
  int quota0 [NC];
  int quota1 [NC];
  logic [NC-1:0] en0, en1;

  logic [SW-1:0] q0 [$];
  logic [SW-1:0] q1 [$];
  int t0 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] smp(input int c, input int k, input bit last);
    logic [DW-1:0] d;
    logic [CW-1:0] ch;
    d  = DW'(c * 256 + k);
    ch = CW'(c);
    return {last, ch, d};
  endfunction

  // Data on channel c is c*256 + its own handshake count.
  task automatic refresh();
    for (int c = 0; c < NC; c++) begin
      bus0.sched_valid_in[c] = en0[c] && (quota0[c] > 0);
      bus1.sched_valid_in[c] = en1[c] && (quota1[c] > 0);
      bus0.sched_data_in[c*DW +: DW] = DW'(c * 256 + seq0[c]);
      bus1.sched_data_in[c*DW +: DW] = DW'(c * 256 + seq1[c]);
    end
  endtask

  task automatic cycle();
    logic [NC-1:0] h0, h1;
    @(negedge clk);
    h0 = bus0.sched_valid_in & bus0.sched_ready_in;
    h1 = bus1.sched_valid_in & bus1.sched_ready_in;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        if (h0[c]) begin seq0[c]++; quota0[c]--; end
        if (h1[c]) begin seq1[c]++; quota1[c]--; end
      end
    end
    refresh();
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk({nm, " drained"}, q0.size() + q1.size(), 0);
    repeat (3) cycle();
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, " dut0 valid_out"}, bus0.sched_valid_out, 0);
    chk({nm, " dut0 data_out"},  bus0.sched_data_out, 0);
    chk({nm, " dut0 chan_out"},  bus0.sched_chan_out, 0);
    chk({nm, " dut0 last_out"},  bus0.sched_last_out, 0);
    chk({nm, " dut0 ready_in"},  bus0.sched_ready_in, 0);
    chk({nm, " dut1 valid_out"}, bus1.sched_valid_out, 0);
    chk({nm, " dut1 ready_in"},  bus1.sched_ready_in, 0);
  endtask

  always @(negedge clk) begin
    if (rst && bus0.sched_valid_out && bus0.sched_ready_out) begin
      t0.push_back(cyc);
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut0 unexpected sample: got 0x%0h required none",
                 {bus0.sched_last_out, bus0.sched_chan_out, bus0.sched_data_out});
      end else begin
        chk("dut0 sample", int'({bus0.sched_last_out, bus0.sched_chan_out, bus0.sched_data_out}),
            int'(q0.pop_front()));
      end
    end
    if (rst && bus1.sched_valid_out && bus1.sched_ready_out) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1 unexpected sample: got 0x%0h required none",
                 {bus1.sched_last_out, bus1.sched_chan_out, bus1.sched_data_out});
      end else begin
        chk("dut1 sample", int'({bus1.sched_last_out, bus1.sched_chan_out, bus1.sched_data_out}),
            int'(q1.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, n;
    for (int c = 0; c < NC; c++) begin
      seq0[c] = 0; seq1[c] = 0; quota0[c] = 0; quota1[c] = 0;
    end
    en0 = '1;
    en1 = '1;
    bus0.sched_ready_out = 1'b1;
    bus1.sched_ready_out = 1'b1;
    refresh();
    rst = 1'b0;
    repeat (3) cycle();
    reset_checks("por");
    rst = 1'b1;
    cycle();

    // BURST_LEN=1: ch0 and ch3 alternate, every sample is a window end
    quota1[0] = 3;
    quota1[3] = 3;
    refresh();
    for (int k = 0; k < 3; k++) begin
      q1.push_back(smp(0, k, 1'b1));
      q1.push_back(smp(3, k, 1'b1));
    end
    drain("burst1", 60);

    // All channels valid: ch0, ch1, ch2, ch3, ch0 windows of 4
    t0.delete();
    quota0[0] = 8; quota0[1] = 4; quota0[2] = 4; quota0[3] = 4;
    refresh();
    for (int k = 0; k < 4; k++) q0.push_back(smp(0, k, k == 3));
    for (int c = 1; c < NC; c++)
      for (int k = 0; k < 4; k++) q0.push_back(smp(c, k, k == 3));
    for (int k = 4; k < 8; k++) q0.push_back(smp(0, k, k == 7));
    drain("all valid", 120);
    chk("samples seen", t0.size(), 20);
    chk("in-window spacing", t0[1] - t0[0], 1);
    chk("window bubble", t0[4] - t0[3], 2);
    chk("20-sample span", t0[19] - t0[0], 23);

    // Only ch2 after reset: two consecutive ch2 windows
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    quota0[2] = 8;
    refresh();
    for (int k = 4; k < 12; k++) q0.push_back(smp(2, k, (k == 7) || (k == 11)));
    drain("ch2 only", 60);

    // Downstream stall mid-burst on ch3
    quota0[3] = 4;
    refresh();
    for (int k = 4; k < 8; k++) q0.push_back(smp(3, k, k == 7));
    base = t0.size();
    n = 0;
    while (t0.size() < base + 2 && n < 40) begin cycle(); n++; end
    chk("stall setup", t0.size(), base + 2);
    bus0.sched_ready_out = 1'b0;
    repeat (5) begin
      cycle();
      chk("stall valid_out", bus0.sched_valid_out, 1);
      chk("stall data_out",  bus0.sched_data_out, 3 * 256 + 6);
      chk("stall chan_out",  bus0.sched_chan_out, 3);
      chk("stall last_out",  bus0.sched_last_out, 0);
      chk("stall ready_in",  bus0.sched_ready_in, 0);
    end
    bus0.sched_ready_out = 1'b1;
    drain("stall", 40);

    // ch0 window moves rr_ptr to 1, then ch1 pauses while ch0 waits
    quota0[0] = 4;
    refresh();
    for (int k = 8; k < 12; k++) q0.push_back(smp(0, k, k == 11));
    drain("ch0 pre", 40);
    quota0[0] = 4;
    quota0[1] = 4;
    refresh();
    for (int k = 4; k < 8; k++) q0.push_back(smp(1, k, k == 7));
    for (int k = 12; k < 16; k++) q0.push_back(smp(0, k, k == 15));
    n = 0;
    while (seq0[1] < 6 && n < 40) begin cycle(); n++; end
    chk("pause setup", seq0[1], 6);
    en0[1] = 1'b0;
    refresh();
    repeat (3) begin
      cycle();
      chk("pause ready_in", bus0.sched_ready_in, 4'b0010);
    end
    en0[1] = 1'b1;
    refresh();
    drain("pause", 60);

    // Reset mid-burst with a held sample, then arbitration restarts at ch0
    quota0[2] = 4;
    refresh();
    for (int k = 12; k < 16; k++) q0.push_back(smp(2, k, k == 15));
    base = t0.size();
    n = 0;
    while (t0.size() < base + 1 && n < 40) begin cycle(); n++; end
    chk("midreset valid before", bus0.sched_valid_out, 1);
    rst = 1'b0;
    cycle();
    reset_checks("midreset");
    q0.delete();
    quota0[2] = 0;
    rst = 1'b1;
    quota0[0] = 4;
    quota0[3] = 4;
    refresh();
    for (int k = 16; k < 20; k++) q0.push_back(smp(0, k, k == 19));
    for (int k = 8; k < 12; k++) q0.push_back(smp(3, k, k == 11));
    drain("post reset", 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/subsample_scheduler.md
# subsample_scheduler

Time-multiplexes NUM_CHANNELS independent sample streams onto one shared subsample stage. It holds a grant on one channel for a whole window of BURST_LEN accepted samples, so each channel's window reaches the shared stage contiguously. It then moves to the next requesting channel in round-robin order. It sits between the per-channel front ends and the single subsample instance, and tags every forwarded sample with its channel index.

## Interface
- NUM_CHANNELS, 4, number of requesting streams (≥1)
- DATA_WIDTH, 12, sample width
- BURST_LEN, 400, samples per grant; must equal the downstream SUBSAMPLE_FACTOR (≥1)
- clk  input  1  sole clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- sched_valid_in  input  NUM_CHANNELS  per-channel valid
- sched_ready_in  output  NUM_CHANNELS  per-channel ready, at most one bit set
- sched_data_in  input  NUM_CHANNELS*DATA_WIDTH  channel c in bits [c*DATA_WIDTH +: DATA_WIDTH]
- sched_ready_out  input  1  downstream ready
- sched_valid_out  output  1  registered valid
- sched_data_out  output  DATA_WIDTH  registered sample
- sched_chan_out  output  CHAN_WIDTH  channel index of sched_data_out
- sched_last_out  output  1  high on the final sample of a window

## Operation
- State machine sched_state_t has two states: IDLE and BURST.
- IDLE:
  - Search sched_valid_in starting at rr_ptr, wrapping NUM_CHANNELS-1→0.
  - On the first set bit: grant <= that index, count <= 0, go to BURST.
  - If no bit is set, stay in IDLE.
  - All sched_ready_in bits are 0 in IDLE.
- BURST:
  - sched_ready_in[grant] = !sched_valid_out || sched_ready_out. All other ready bits are 0.
  - On input handshake (valid_in[grant] && ready_in[grant]): data_out <= data_in[grant], chan_out <= grant, last_out <= (count == BURST_LEN-1), valid_out <= 1.
  - If count < BURST_LEN-1, count++. Otherwise count <= 0, rr_ptr <= (grant+1) mod NUM_CHANNELS, go to IDLE.
- Output register: on output handshake with no same-cycle input handshake, valid_out <= 0. A simultaneous input and output handshake reloads the register, keeping valid at 1.
- Grant is never revoked mid-window. If the granted channel deasserts valid, the scheduler waits indefinitely. There is no timeout.
- Valid on non-granted channels is ignored until their turn.
- BURST_LEN=1: every sample has last_out=1, and a single-beat burst returns to IDLE.
- NUM_CHANNELS=1: rr_ptr and chan_out stay at 0.
- Reset values:
  - sched_valid_out=0, sched_data_out=0, sched_chan_out=0, sched_last_out=0.
  - sched_ready_in=0 (state IDLE), rr_ptr=0, grant=0, count=0.
- Reset mid-burst discards the partial window and any held output sample. After reset, arbitration restarts at channel 0.

## Timing
- Input-to-output latency is 1 cycle: a sample accepted on edge N is valid on the outputs after edge N.
- Within a burst, throughput is one sample per cycle while downstream is ready.
- Between bursts there is exactly one IDLE cycle. The output register keeps draining during it.
- First grant: requests sampled in IDLE at edge N give ready_in[grant] high in the cycle after edge N.
- While valid_out=1 and ready_out=0, data_out, chan_out and last_out stay stable.
- valid_out never depends combinationally on ready_out. sched_ready_in depends combinationally on sched_ready_out, state and grant.

## Structure
- cnn1d_pkg holds:
  - sched_state_t enum {IDLE, BURST}
  - the existing clog2
- Local widths:
  - CHAN_WIDTH = max(1, clog2(NUM_CHANNELS))
  - COUNTER_WIDTH = max(1, clog2(BURST_LEN))
- Sub-module rr_pick: a combinational round-robin priority search. Inputs are the request vector and the start pointer. Outputs are found and index. It is reusable by other shared-resource schedulers.

## Test plan
- NUM_CHANNELS=4, BURST_LEN=4, all channels valid, ready_out=1 → 4 samples from ch0, then ch1, ch2, ch3, ch0. last_out is set on every 4th sample, with a single bubble cycle between windows.
- Only ch2 valid after reset → grant ch2, chan_out=2. After its window, rr_ptr=3; ch2 is granted again once the search wraps.
- ready_out held low for 5 cycles mid-burst → valid_out stays 1 with data, chan and last stable, ready_in[grant]=0, and count does not advance.
- Granted ch1 drops valid for 3 cycles at sample 2 of 4 while ch0 is valid → no switch to ch0. Sample 3 comes from ch1 when it resumes.
- BURST_LEN=1, ch0 and ch3 valid → alternating ch0/ch3 single samples, every one with last_out=1.
- rst driven low mid-burst with valid_out=1 → next cycle all outputs are 0 and ready_in=0. Arbitration then restarts at ch0.
